apb_gpio_slave_if: RTL and testbench

//  APB3/APB4 slave front-end directly upstream of the GPIO register block. Converts
//  APB SETUP/ACCESS phases into gpio_wr_en/gpio_rd_en strobes, latched address/data/strobe,
//  and returns gpio_rdata/gpio_error to the bus as PRDATA/PSLVERR with registered PREADY.

---
 rtl/gpio_apb_pkg.sv | 25 ++
 rtl/apb_dn_counter.sv | 29 ++
 rtl/apb_gpio_slave_if.sv | 159 +++++++++++++++
 tb/tb_apb_gpio_slave_if.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_apb_pkg.sv
// Shared types and sizing helpers for the APB-to-GPIO slave front-end.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package gpio_apb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} apb_state_e;

  localparam int unsigned DEF_WAIT_STATES = 0;
  localparam int unsigned DEF_TIMEOUT_CYC = 16;

  // Counter must hold the larger of the wait-state and timeout preloads.
  function automatic int unsigned cnt_width(input int unsigned ws, input int unsigned to);
    int unsigned m;
    m = (ws > to) ? ws : to;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

  localparam int unsigned APB_CNT_W = cnt_width(DEF_WAIT_STATES, DEF_TIMEOUT_CYC);

endpackage

// File: rtl/apb_dn_counter.sv
// Loadable saturating down-counter with a zero flag; shared by wait-state and timeout timing.
module apb_dn_counter
  import gpio_apb_pkg::*;
#(
  parameter int unsigned W = APB_CNT_W
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/apb_gpio_slave_if.sv
// APB3/APB4 slave front-end turning SETUP/ACCESS phases into single GPIO access strobes.
// Optional feature: define APB_GPIO_TIMEOUT_EN to bound the ISSUE phase by TIMEOUT_CYC cycles.
module apb_gpio_slave_if
  import gpio_apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = `ADDR_WIDTH,
  parameter int unsigned DATA_W      = `DATA_WIDTH,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic                PREADY,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PSLVERR,
  output logic                gpio_wr_en,
  output logic                gpio_rd_en,
  output logic [ADDR_W-1:0]   gpio_reg_addr,
  output logic [DATA_W-1:0]   gpio_wdata,
  output logic [DATA_W/8-1:0] gpio_strb,
  input  logic [DATA_W-1:0]   gpio_rdata,
  input  logic                gpio_ready,
  input  logic                gpio_error
);

  localparam int unsigned CNT_W = cnt_width(WAIT_STATES, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] WAIT_LOAD    = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  apb_state_e       state;
  logic             write_q;
  logic             setup;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero_c;

  assign setup = PSEL && !PENABLE;

  apb_dn_counter #(.W(CNT_W)) u_cnt (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  // Counter preloads one less than the cycle count so "zero" marks the last cycle.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        if (setup) begin
          cnt_load = 1'b1;
          cnt_val  = (WAIT_STATES > 0) ? WAIT_LOAD : TIMEOUT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_zero_c) begin
          cnt_load = 1'b1;
          cnt_val  = TIMEOUT_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef APB_GPIO_TIMEOUT_EN
      ISSUE: cnt_dec = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      write_q       <= 1'b0;
      PREADY        <= 1'b0;
      PRDATA        <= '0;
      PSLVERR       <= 1'b0;
      gpio_wr_en    <= 1'b0;
      gpio_rd_en    <= 1'b0;
      gpio_reg_addr <= '0;
      gpio_wdata    <= '0;
      gpio_strb     <= '0;
    end else begin
      PREADY     <= 1'b0;
      gpio_wr_en <= 1'b0;
      gpio_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
          if (setup) begin
            write_q       <= PWRITE;
            gpio_reg_addr <= PADDR;
            gpio_wdata    <= PWDATA;
            gpio_strb     <= PWRITE ? PSTRB : '0;
            if (PADDR[1:0] != 2'b00) begin
              state   <= RESP;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state <= WAIT;
            end else begin
              state      <= ISSUE;
              gpio_wr_en <= PWRITE;
              gpio_rd_en <= !PWRITE;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (cnt_zero_c) begin
            state      <= ISSUE;
            gpio_wr_en <= write_q;
            gpio_rd_en <= !write_q;
          end
        end
        ISSUE: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (gpio_ready) begin
            state   <= RESP;
            PREADY  <= 1'b1;
            PRDATA  <= write_q ? '0 : gpio_rdata;
            PSLVERR <= gpio_error;
`ifdef APB_GPIO_TIMEOUT_EN
          end else if (cnt_zero_c) begin
            state   <= RESP;
            PREADY  <= 1'b1;
            PRDATA  <= '0;
            PSLVERR <= 1'b1;
`endif
          end else begin
            gpio_wr_en <= write_q;
            gpio_rd_en <= !write_q;
          end
        end
        RESP: begin
          state   <= IDLE;
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gpio_slave_if.sv
// Directed bench for apb_gpio_slave_if: one instance with no wait states, one with three.
module tb_apb_gpio_slave_if;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel0, psel3, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, gpio_rdata;
  logic [3:0]  PSTRB;
  logic        gpio_ready, gpio_error;

  logic        pready0, pslverr0, wr0, rd0;
  logic [31:0] prdata0, addr0, wdata0;
  logic [3:0]  strb0;
  logic        pready3, pslverr3, wr3, rd3;
  logic [31:0] prdata3, addr3, wdata3;
  logic [3:0]  strb3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_gpio_slave_if #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0), .TIMEOUT_CYC(16)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(pready0), .PRDATA(prdata0),
    .PSLVERR(pslverr0), .gpio_wr_en(wr0), .gpio_rd_en(rd0), .gpio_reg_addr(addr0),
    .gpio_wdata(wdata0), .gpio_strb(strb0), .gpio_rdata(gpio_rdata),
    .gpio_ready(gpio_ready), .gpio_error(gpio_error)
  );

  apb_gpio_slave_if #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(3), .TIMEOUT_CYC(16)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(pready3), .PRDATA(prdata3),
    .PSLVERR(pslverr3), .gpio_wr_en(wr3), .gpio_rd_en(rd3), .gpio_reg_addr(addr3),
    .gpio_wdata(wdata3), .gpio_strb(strb3), .gpio_rdata(gpio_rdata),
    .gpio_ready(gpio_ready), .gpio_error(gpio_error)
  );

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic s0, input logic s3, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    psel0   = s0;
    psel3   = s3;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = wdata;
    PSTRB   = strb;
  endtask

  task automatic idle_bus;
    psel0   = 1'b0;
    psel3   = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0; psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; gpio_rdata = '0; gpio_ready = 1'b1; gpio_error = 1'b0;
    tick; tick;
    chk_b("rst_pready", pready0, 1'b0);
    chk_w("rst_prdata", prdata0, 32'h0);
    chk_b("rst_pslverr", pslverr0, 1'b0);
    chk_b("rst_wr_en", wr0, 1'b0);
    chk_b("rst_rd_en3", rd3, 1'b0);
    chk_w("rst_addr", addr0, 32'h0);
    PRESETn = 1'b1;
    tick;

    // Zero-wait write: strobe at T+1, PREADY at T+2
    setup(1'b1, 1'b0, 1'b1, 32'h4, 32'hA5A5_00FF, 4'b0011);
    tick;
    PENABLE = 1'b1;
    chk_b("wr_strobe", wr0, 1'b1);
    chk_b("wr_no_rd", rd0, 1'b0);
    chk_w("wr_addr", addr0, 32'h4);
    chk_w("wr_wdata", wdata0, 32'hA5A5_00FF);
    chk_w("wr_strb", 32'(strb0), 32'h3);
    chk_b("wr_pready_early", pready0, 1'b0);
    tick;
    chk_b("wr_pready", pready0, 1'b1);
    chk_b("wr_strobe_drop", wr0, 1'b0);
    chk_b("wr_pslverr", pslverr0, 1'b0);
    chk_b("wr_dut3_quiet", wr3, 1'b0);
    idle_bus;
    tick;
    chk_b("wr_pready_one_cycle", pready0, 1'b0);

    // Three-wait read: strobe at T+4, PREADY at T+5, read strobes masked
    gpio_rdata = 32'h0000_1234;
    setup(1'b0, 1'b1, 1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF);
    tick;
    PENABLE = 1'b1;
    chk_b("rd_wait1", rd3, 1'b0);
    tick;
    chk_b("rd_wait2", rd3, 1'b0);
    tick;
    chk_b("rd_wait3", rd3, 1'b0);
    tick;
    chk_b("rd_strobe", rd3, 1'b1);
    chk_b("rd_no_wr", wr3, 1'b0);
    chk_w("rd_strb_forced0", 32'(strb3), 32'h0);
    chk_w("rd_addr", addr3, 32'h8);
    chk_b("rd_pready_early", pready3, 1'b0);
    tick;
    chk_b("rd_pready", pready3, 1'b1);
    chk_w("rd_prdata", prdata3, 32'h0000_1234);
    chk_b("rd_strobe_drop", rd3, 1'b0);
    idle_bus;
    tick;
    chk_w("rd_prdata_clear", prdata3, 32'h0);
    chk_b("rd_pready_one_cycle", pready3, 1'b0);

    // GPIO decode error on undefined address
    gpio_error = 1'b1;
    setup(1'b1, 1'b0, 1'b1, 32'h40, 32'h0000_0001, 4'hF);
    tick;
    PENABLE = 1'b1;
    chk_b("err_strobe", wr0, 1'b1);
    tick;
    chk_b("err_pready", pready0, 1'b1);
    chk_b("err_pslverr", pslverr0, 1'b1);
    chk_w("err_prdata", prdata0, 32'h0);
    idle_bus;
    gpio_error = 1'b0;
    tick;
    chk_b("err_pslverr_clear", pslverr0, 1'b0);

    // Misaligned address: no strobe, immediate error response
    setup(1'b1, 1'b0, 1'b1, 32'h6, 32'h1234_5678, 4'hF);
    tick;
    PENABLE = 1'b1;
    chk_b("mis_no_wr", wr0, 1'b0);
    chk_b("mis_no_rd", rd0, 1'b0);
    chk_b("mis_pready", pready0, 1'b1);
    chk_b("mis_pslverr", pslverr0, 1'b1);
    idle_bus;
    tick;
    chk_b("mis_pready_clear", pready0, 1'b0);
    chk_b("mis_pslverr_clear", pslverr0, 1'b0);

    // Back-to-back reads with a new SETUP right after RESP
    gpio_rdata = 32'h11;
    setup(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 4'h0);
    tick;
    PENABLE = 1'b1;
    chk_b("b2b_rd1", rd0, 1'b1);
    tick;
    chk_b("b2b_pready1", pready0, 1'b1);
    chk_w("b2b_prdata1", prdata0, 32'h11);
    tick;
    chk_b("b2b_gap_pready", pready0, 1'b0);
    chk_w("b2b_gap_prdata", prdata0, 32'h0);
    gpio_rdata = 32'h22;
    setup(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    tick;
    PENABLE = 1'b1;
    chk_b("b2b_rd2", rd0, 1'b1);
    chk_w("b2b_addr2", addr0, 32'h10);
    tick;
    chk_b("b2b_pready2", pready0, 1'b1);
    chk_w("b2b_prdata2", prdata0, 32'h22);
    idle_bus;
    tick;

    // PENABLE without a SETUP phase is ignored
    psel0 = 1'b1;
    PENABLE = 1'b1;
    tick; tick;
    chk_b("noset_wr", wr0, 1'b0);
    chk_b("noset_rd", rd0, 1'b0);
    chk_b("noset_pready", pready0, 1'b0);
    idle_bus;
    tick;

    // PSEL dropped during ISSUE aborts without PREADY
    gpio_ready = 1'b0;
    setup(1'b1, 1'b0, 1'b1, 32'h20, 32'h77, 4'hF);
    tick;
    PENABLE = 1'b1;
    chk_b("abort_strobe", wr0, 1'b1);
    tick;
    chk_b("abort_strobe_held", wr0, 1'b1);
    idle_bus;
    tick;
    chk_b("abort_strobe_low", wr0, 1'b0);
    chk_b("abort_no_pready", pready0, 1'b0);
    tick;
    chk_b("abort_no_pready_late", pready0, 1'b0);

    // PSEL dropped during WAIT: the write is never issued
    gpio_ready = 1'b1;
    setup(1'b0, 1'b1, 1'b1, 32'h24, 32'h99, 4'hF);
    tick;
    idle_bus;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_b("wabort_no_wr", wr3, 1'b0);
      chk_b("wabort_no_pready", pready3, 1'b0);
    end

    // Asynchronous reset in the middle of ISSUE
    gpio_ready = 1'b0;
    setup(1'b1, 1'b0, 1'b1, 32'h28, 32'hCAFE, 4'h3);
    tick;
    PENABLE = 1'b1;
    chk_b("arst_pre_strobe", wr0, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk_b("arst_wr", wr0, 1'b0);
    chk_w("arst_addr", addr0, 32'h0);
    chk_w("arst_wdata", wdata0, 32'h0);
    chk_w("arst_strb", 32'(strb0), 32'h0);
    chk_b("arst_pready", pready0, 1'b0);
    idle_bus;
    tick;
    PRESETn = 1'b1;
    tick;
    chk_b("arst_idle_wr", wr0, 1'b0);

    // Stalled read: timeout build closes with an error, default build keeps waiting
    gpio_rdata = 32'h55;
    setup(1'b1, 1'b0, 1'b0, 32'h2C, 32'h0, 4'h0);
    tick;
    PENABLE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_b("stall_strobe", rd0, 1'b1);
      tick;
    end
`ifdef APB_GPIO_TIMEOUT_EN
    chk_b("to_strobe_drop", rd0, 1'b0);
    chk_b("to_pready", pready0, 1'b1);
    chk_b("to_pslverr", pslverr0, 1'b1);
    chk_w("to_prdata", prdata0, 32'h0);
    idle_bus;
    tick;
    chk_b("to_pready_clear", pready0, 1'b0);
`else
    chk_b("stall_strobe_held", rd0, 1'b1);
    chk_b("stall_no_pready", pready0, 1'b0);
    idle_bus;
    tick;
    chk_b("stall_abort_rd", rd0, 1'b0);
    chk_b("stall_abort_pready", pready0, 1'b0);
`endif
    gpio_ready = 1'b1;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
